// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: turns the LC-3 control unit's level-style Mem_OE/Mem_WE
// requests into timed, glitch-free SRAM strobe sequences with configurable
// wait states, and returns read data plus a one-cycle Mem_Ready pulse.
// Optional feature macro: IO_MAP_EN (MAR==IO_ADDR maps to Switches/HEX_Data
// instead of the SRAM).
module sram_access_ctrl #(
    parameter int          RD_WAIT = 2,
    parameter int          WR_WAIT = 2,
    parameter int          ADDR_W  = 20,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [15:0]       MAR,
    input  logic [15:0]       MDR,
    input  logic [15:0]       Data_from_SRAM,
    input  logic [15:0]       Switches,
    output logic [15:0]       Data_to_CPU,
    output logic              Mem_Ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [15:0]       Data_to_SRAM,
    output logic              Data_drive,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic              UB_N,
    output logic              LB_N,
    output logic [15:0]       HEX_Data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE,
        S_RELEASE
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                r_io;
    logic                w_io_next;
    logic                w_io_hit;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [ADDR_W-1:0]   w_sram_addr_next;
    logic [15:0]         r_wdata;
    logic [15:0]         w_wdata_next;
    logic [15:0]         r_rdata;
    logic [15:0]         w_rdata_next;
    logic [15:0]         r_hex;
    logic [15:0]         w_hex_next;
    logic [15:0]         w_capture;

    // Registered strobes and their next-cycle values
    logic r_ce_n, r_oe_n, r_we_n, r_bytes_n, r_drive, r_ready;
    logic w_ce_n_next, w_oe_n_next, w_we_n_next, w_bytes_n_next, w_drive_next, w_ready_next;

`ifdef IO_MAP_EN
    // The I/O address bypasses the SRAM: reads sample the switches
    assign w_io_hit  = (MAR == IO_ADDR);
    assign w_capture = r_io ? Switches : Data_from_SRAM;
`else
    logic w_unused_io;
    assign w_unused_io = ^{Switches, IO_ADDR};
    assign w_io_hit    = 1'b0;
    assign w_capture   = Data_from_SRAM;
`endif

    // Next-state, wait counter and datapath latches
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_io_next        = r_io;
        w_sram_addr_next = r_sram_addr;
        w_wdata_next     = r_wdata;
        w_rdata_next     = r_rdata;
        w_hex_next       = r_hex;
        unique case (r_state)
            S_IDLE: begin
                // Write wins when both requests are raised together
                if (Mem_WE) begin
                    w_state_next     = S_WR_SETUP;
                    w_cnt_next       = WR_LOAD;
                    w_io_next        = w_io_hit;
                    w_sram_addr_next = ADDR_W'(MAR);
                    w_wdata_next     = MDR;
                end else if (Mem_OE) begin
                    w_state_next     = S_RD;
                    w_cnt_next       = RD_LOAD;
                    w_io_next        = w_io_hit;
                    w_sram_addr_next = ADDR_W'(MAR);
                    w_wdata_next     = MDR;
                end
            end
            S_RD: begin
                if (r_cnt == 4'd0) begin
                    w_rdata_next = w_capture;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_WR_SETUP: begin
                w_state_next = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_WR_HOLD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_WR_HOLD: begin
`ifdef IO_MAP_EN
                if (r_io) begin
                    w_hex_next = r_wdata;
                end
`endif
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
                // Wait for both levels to drop so a held request is not reissued
                if (!Mem_OE && !Mem_WE) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Strobe values decoded from the next state so they register glitch-free
    always_comb begin
        w_ce_n_next    = 1'b1;
        w_oe_n_next    = 1'b1;
        w_we_n_next    = 1'b1;
        w_bytes_n_next = 1'b1;
        w_drive_next   = 1'b0;
        w_ready_next   = (w_state_next == S_DONE);
        if (!w_io_next) begin
            unique case (w_state_next)
                S_RD: begin
                    w_ce_n_next    = 1'b0;
                    w_oe_n_next    = 1'b0;
                    w_bytes_n_next = 1'b0;
                end
                S_WR_SETUP, S_WR_HOLD: begin
                    w_ce_n_next  = 1'b0;
                    w_drive_next = 1'b1;
                end
                S_WR_PULSE: begin
                    w_ce_n_next    = 1'b0;
                    w_we_n_next    = 1'b0;
                    w_bytes_n_next = 1'b0;
                    w_drive_next   = 1'b1;
                end
                default: begin
                    w_ce_n_next = 1'b1;
                end
            endcase
        end
    end

    // State, counter and datapath registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_io        <= 1'b0;
            r_sram_addr <= '0;
            r_wdata     <= 16'h0000;
            r_rdata     <= 16'h0000;
            r_hex       <= 16'h0000;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_io        <= w_io_next;
            r_sram_addr <= w_sram_addr_next;
            r_wdata     <= w_wdata_next;
            r_rdata     <= w_rdata_next;
            r_hex       <= w_hex_next;
        end
    end

    // Strobe and completion registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_bytes_n <= 1'b1;
            r_drive   <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_ce_n    <= w_ce_n_next;
            r_oe_n    <= w_oe_n_next;
            r_we_n    <= w_we_n_next;
            r_bytes_n <= w_bytes_n_next;
            r_drive   <= w_drive_next;
            r_ready   <= w_ready_next;
        end
    end

    assign Data_to_CPU  = r_rdata;
    assign Mem_Ready    = r_ready;
    assign SRAM_ADDR    = r_sram_addr;
    assign Data_to_SRAM = r_wdata;
    assign Data_drive   = r_drive;
    assign CE_N         = r_ce_n;
    assign OE_N         = r_oe_n;
    assign WE_N         = r_we_n;
    assign UB_N         = r_bytes_n;
    assign LB_N         = r_bytes_n;
    assign HEX_Data     = r_hex;

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Memory access controller downstream of the LC-3 control unit. It converts the control unit's level-style Mem_OE/Mem_WE requests, with the MAR/MDR contents, into timed SRAM strobe sequences with configurable wait states. It returns read data plus a one-cycle completion pulse to the datapath MDR mux.

Parameters:
RD_WAIT, 2, cycles OE_N held low before read data is captured (1..15)
WR_WAIT, 2, cycles WE_N held low during a write (1..15)
ADDR_W, 20, SRAM address width; upper bits above 16 driven 0
IO_ADDR, 16'hFFFF, memory-mapped I/O address (used only with IO_MAP_EN)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
Mem_OE  in  1  read request from control unit, active-high level
Mem_WE  in  1  write request from control unit, active-high level
MAR  in  16  access address
MDR  in  16  write data
Data_from_SRAM  in  16  SRAM data bus input
Switches  in  16  board switches (I/O read source)
Data_to_CPU  out  16  read data to the MDR mux, registered
Mem_Ready  out  1  one-cycle pulse when the access completes
SRAM_ADDR  out  ADDR_W  SRAM address, registered
Data_to_SRAM  out  16  SRAM write data, registered
Data_drive  out  1  tristate enable for the SRAM data bus
CE_N, OE_N, WE_N, UB_N, LB_N  out  1 each  SRAM strobes, active-low
HEX_Data  out  16  hex display register (I/O write target)

Behaviour:
- Reset, applied at a clock edge while Reset_n=0:
  - state IDLE
  - CE_N=OE_N=WE_N=UB_N=LB_N=1, Data_drive=0
  - Mem_Ready=0, Data_to_CPU=0, HEX_Data=0, SRAM_ADDR=0, Data_to_SRAM=0
  - A reset mid-access aborts it. No Mem_Ready is issued.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE, RELEASE.
- IDLE:
  - Mem_WE=1 goes to WR_SETUP. Write has priority if Mem_OE=Mem_WE=1.
  - Else Mem_OE=1 goes to RD.
  - On either transition, latch MAR into SRAM_ADDR (zero-extended) and MDR into Data_to_SRAM. A 4-bit wait counter loads RD_WAIT-1 or WR_WAIT-1.
- RD:
  - CE_N=0, OE_N=0, UB_N=LB_N=0. The counter decrements each cycle.
  - When counter=0, capture Data_from_SRAM into Data_to_CPU and go to DONE.
  - The SRAM read strobe is active for exactly RD_WAIT cycles.
- WR_SETUP: CE_N=0, Data_drive=1, WE_N=1, for 1 cycle.
- WR_PULSE: CE_N=0, Data_drive=1, WE_N=0, UB_N=LB_N=0, for WR_WAIT cycles.
- WR_HOLD: CE_N=0, Data_drive=1, WE_N=1, for 1 cycle. Data stays stable after the WE_N rising edge. Next state is DONE.
- DONE: Mem_Ready=1 for exactly one cycle. Go to RELEASE.
- RELEASE: all strobes inactive. Stay until Mem_OE=0 and Mem_WE=0, then go to IDLE. A level held high across an access never triggers a second access.
- Latency:
  - Read: request seen in IDLE at edge T0. Mem_Ready is high in cycle T0+RD_WAIT+1, and Data_to_CPU is valid from that cycle.
  - Write: Mem_Ready is high in cycle T0+WR_WAIT+3.
- MAR/MDR changes after acceptance are ignored until the next IDLE.
- Data_to_CPU holds its last value until the next read capture.
- Outputs are all registered. No strobe glitches.
- OE_N and WE_N are never low in the same cycle. Data_drive=1 never coincides with OE_N=0.

Optional Feature:
IO_MAP_EN:
- Defined: an access with MAR==IO_ADDR does not touch the SRAM; all strobes stay inactive.
  - Read takes the same RD_WAIT timing and captures Switches into Data_to_CPU.
  - Write loads MDR into HEX_Data at the transition into DONE, with the same write timing.
- Undefined: IO_ADDR is ordinary SRAM space. HEX_Data stays 0. Switches is unused.

Test Plan:
- Reset_n=0 mid-RD (RD_WAIT=2) -> next cycle OE_N=CE_N=1, Mem_Ready never pulses, Data_to_CPU=0, state IDLE.
- Mem_OE=1, MAR=16'h3000, SRAM model returns 16'hBEEF -> OE_N low 2 cycles, SRAM_ADDR=20'h03000, Mem_Ready single pulse at T0+3, Data_to_CPU=16'hBEEF.
- Mem_WE=1, MAR=16'h0042, MDR=16'h1234 -> WE_N low exactly 2 cycles, framed by 1 setup and 1 hold cycle with Data_drive=1 and Data_to_SRAM=16'h1234; Mem_Ready at T0+5.
- Mem_OE held high 8 cycles -> exactly one access and one Mem_Ready pulse; the second access starts only after Mem_OE drops and rises again.
- Mem_OE=Mem_WE=1 together -> write sequence performed, OE_N stays 1 throughout.
- IO_MAP_EN defined: write MAR=16'hFFFF, MDR=16'h00A5 -> HEX_Data=16'h00A5, CE_N stays 1; read with Switches=16'h0F0F -> Data_to_CPU=16'h0F0F.
